// File: rtl/link_rx_buffer.sv
// link_rx_buffer: responder end of a 4-phase req/ack byte link.
// Captures one byte per handshake into a circular FIFO, raises ack a fixed
// number of cycles after capture, and lets downstream logic drain the FIFO
// through a valid/ready port. Also tracks a saturating byte count, the last
// accepted byte and a sticky done flag.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   link request; data_in valid while high
//   data_in    in   [7:0] link byte
//   ack        out  link acknowledge (registered)
//   out_valid  out  FIFO non-empty
//   out_data   out  [7:0] registered FIFO head
//   out_ready  in   pop head when out_valid && out_ready
//   byte_cnt   out  [7:0] bytes accepted since reset, saturating
//   last_byte  out  [7:0] most recently accepted byte
//   done       out  sticky, set once byte_cnt reaches EXPECT_BYTES
module link_rx_buffer #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned ACK_DELAY    = 2,
   parameter int unsigned EXPECT_BYTES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [7:0] data_in,
   output logic       ack,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic [7:0] byte_cnt,
   output logic [7:0] last_byte,
   output logic       done
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned DW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
   localparam logic [DW-1:0] DLY_LOAD = (ACK_DELAY > 0) ? DW'(ACK_DELAY - 1) : '0;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [7:0]    EXP_CNT  = 8'(EXPECT_BYTES);

   typedef enum logic [1:0] {StIdle, StDelay, StAck} state_e;

   state_e          state_q, state_d;
   logic            ack_q, ack_d;
   logic [DW-1:0]   dly_q, dly_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   rd_next;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      head_q, head_d;
   logic [7:0]      byte_cnt_q, byte_cnt_d;
   logic [7:0]      last_q, last_d;
   logic            done_q, done_d;
   logic [7:0]      mem [DEPTH];

   logic push;
   logic pop;

   // Capture only from IDLE, so a req held through DELAY/ACK never recaptures.
   assign push    = (state_q == StIdle) && req && (count_q != FULL_CNT);
   assign pop     = out_ready && (count_q != '0);
   assign rd_next = rd_ptr_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      ack_d      = ack_q;
      dly_d      = dly_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      head_d     = head_q;
      byte_cnt_d = byte_cnt_q;
      last_d     = last_q;
      done_d     = done_q;

      unique case (state_q)
         StIdle: begin
            if (push) begin
               state_d = (ACK_DELAY == 0) ? StAck : StDelay;
               dly_d   = DLY_LOAD;
            end
         end
         StDelay: begin
            if (dly_q == '0) begin
               state_d = StAck;
            end else begin
               dly_d = dly_q - 1'b1;
            end
         end
         StAck: begin
            // ack rises the cycle after entry; a sampled req=0 ends the handshake,
            // including the early-drop case where ack never got to rise.
            if (!req) begin
               state_d = StIdle;
               ack_d   = 1'b0;
            end else begin
               ack_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            ack_d   = 1'b0;
         end
      endcase

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         last_d   = data_in;
         if (byte_cnt_q != 8'hFF) begin
            byte_cnt_d = byte_cnt_q + 8'd1;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_next;
      end

      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end

      // Registered head: after a pop the new head is the next slot, unless the
      // only entry is leaving while a new byte lands in that next slot.
      if (pop) begin
         head_d = (push && (count_q == CW'(1))) ? data_in : mem[rd_next];
      end else if (push && (count_q == '0)) begin
         head_d = data_in;
      end

      if (byte_cnt_d >= EXP_CNT) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ack_q      <= 1'b0;
         dly_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         head_q     <= '0;
         byte_cnt_q <= '0;
         last_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         dly_q      <= dly_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         head_q     <= head_d;
         byte_cnt_q <= byte_cnt_d;
         last_q     <= last_d;
         done_q     <= done_d;
      end
   end

   // Storage needs no reset; only pointers/count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   assign ack       = ack_q;
   assign out_valid = (count_q != '0);
   assign out_data  = head_q;
   assign byte_cnt  = byte_cnt_q;
   assign last_byte = last_q;
   assign done      = done_q;

endmodule

// File: tb/tb_link_rx_buffer.sv
module tb_link_rx_buffer;

   localparam int AD = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0;
   logic [7:0] data_in = '0;
   logic       out_ready = 1'b0;
   logic       ack, out_valid, done;
   logic [7:0] out_data, byte_cnt, last_byte;

   // Second instance with zero ack delay
   logic       req0 = 1'b0;
   logic [7:0] data0 = '0;
   logic       ack0, ov0, done0;
   logic [7:0] od0, bc0, lb0;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   link_rx_buffer #(.DEPTH(4), .ACK_DELAY(AD), .EXPECT_BYTES(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ack(ack),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .byte_cnt(byte_cnt), .last_byte(last_byte), .done(done)
   );

   link_rx_buffer #(.DEPTH(4), .ACK_DELAY(0), .EXPECT_BYTES(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .data_in(data0), .ack(ack0),
      .out_valid(ov0), .out_data(od0), .out_ready(1'b1),
      .byte_cnt(bc0), .last_byte(lb0), .done(done0)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // Scoreboard monitor: every pop seen by the DUT is checked against the queue.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_data: got %02h expected no pop (queue empty)", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
               errors++;
               $display("FAIL pop_data: got %02h expected %02h", out_data, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a rising edge; counts edges until ack is seen high.
   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ack && n < 50);
   endtask

   task automatic send(input logic [7:0] d, input int lat, input bit pulse);
      int n;
      req = 1'b1;
      data_in = d;
      exp_q.push_back(d);
      if (pulse) out_ready = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (pulse && n == 1) out_ready = 1'b0;
      end while (!ack && n < 50);
      if (!ack) chk("ack_timeout", ack, 1);
      else if (lat >= 0) chk("ack_latency", n, lat);
      req = 1'b0;
      @(posedge clk);
      #1;
      chk("ack_fall", ack, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = 1'b0;
      req0 = 1'b0;
      out_ready = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      bit seen;
      logic [7:0] b;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_byte_cnt", byte_cnt, 0);
      chk("rst_last_byte", last_byte, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single byte
      out_ready = 1'b1;
      send(8'hA5, AD + 2, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_drained", exp_q.size(), 0);
      chk("t1_byte_cnt", byte_cnt, 1);
      chk("t1_last_byte", last_byte, 8'hA5);
      chk("t1_out_valid", out_valid, 0);

      // 2: done after four bytes
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b = 8'(8'h11 * (i + 1));
         send(b, AD + 2, 0);
         chk("t2_done", done, (i == 3) ? 1 : 0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("t2_drained", exp_q.size(), 0);
      chk("t2_last_byte", last_byte, 8'h44);
      chk("t2_done_sticky", done, 1);

      // 3: back-pressure when full
      do_reset();
      for (int i = 1; i <= 4; i++) send(8'(i), AD + 2, 0);
      chk("t3_cnt4", byte_cnt, 4);
      req = 1'b1;
      data_in = 8'h05;
      exp_q.push_back(8'h05);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (ack) seen = 1'b1;
      end
      chk("t3_ack_stuck", seen, 0);
      chk("t3_cnt_held", byte_cnt, 4);
      chk("t3_head", out_data, 8'h01);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      wait_ack(n);
      chk("t3_ack_after_pop", n, AD + 2);
      req = 1'b0;
      @(posedge clk);
      #1;
      chk("t3_ack_fall", ack, 0);
      chk("t3_cnt5", byte_cnt, 5);
      chk("t3_last", last_byte, 8'h05);
      out_ready = 1'b1;
      send(8'h06, -1, 0);
      repeat (8) @(posedge clk);
      #1;
      chk("t3_drained", exp_q.size(), 0);
      chk("t3_empty", out_valid, 0);
      chk("t3_cnt6", byte_cnt, 6);

      // 4: push and pop on the same edge with one entry held, pointers wrap
      do_reset();
      send(8'hB0, AD + 2, 0);
      for (int i = 1; i < 8; i++) begin
         send(8'(8'hB0 + i), AD + 2, 1);
         chk("t4_hold_one", exp_q.size(), 1);
         chk("t4_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t4_drained", exp_q.size(), 0);
      chk("t4_cnt", byte_cnt, 8);

      // 6: reset mid-DELAY
      req = 1'b1;
      data_in = 8'h7E;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req = 1'b0;
      #1;
      chk("t6_ack", ack, 0);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_byte_cnt", byte_cnt, 0);
      chk("t6_last_byte", last_byte, 0);
      chk("t6_done", done, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'h3C, AD + 2, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t6_cnt", byte_cnt, 1);
      chk("t6_last", last_byte, 8'h3C);
      chk("t6_drained", exp_q.size(), 0);

      // 5: zero ack delay, req held long after ack
      req0 = 1'b1;
      data0 = 8'h5A;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ack0 && n < 50);
      chk("t5_latency", n, 2);
      repeat (5) @(posedge clk);
      #1;
      chk("t5_single_capture", bc0, 1);
      chk("t5_ack_held", ack0, 1);
      req0 = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_ack_fall", ack0, 0);
      chk("t5_last", lb0, 8'h5A);
      chk("t5_cnt_final", bc0, 1);

      chk("final_queue", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
